chess_clock_ctrl: RTL and testbench

- Game sequencer for the chess clock. It drives two Timer_Clock instances, timer A (player A) and timer B (player B).
- It owns turn switching, pause/resume, the time-setting mode (per-digit decrement pulses), and flag detection from timer OVERFLOW.
- It sits between the debounced button/prescaler front end and the two timers. It also supplies state to the display mux.

---
 rtl/chess_clock_ctrl.sv | 233 +++++++++++++++++++++++
 tb/tb_chess_clock_ctrl.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/chess_clock_ctrl.sv
// Chess clock game sequencer: turn switching, pause/resume, time-setting
// mode with per-digit decrement pulses, and flag detection from timer
// overflow. Every output is registered, so it shows the decision made from
// the previous cycle's state and inputs.
//
// state   | meaning
// --------+---------------------------------------------------------
// IDLE    | after reset or game end; waiting for set mode or start
// SET     | time-setting mode; SEL picks a digit, BTN_DEC decrements it
// READY   | armed; the first player to press starts the opponent's clock
// RUN_A   | player A's clock is counting
// RUN_B   | player B's clock is counting
// PAUSE   | both clocks halted; DIR records the side to resume
// FLAGGED | a clock ran out; buzzer sounds, flags hold until BTN_SP

module chess_clock_ctrl #(
    parameter int MOVE_W      = 8,
    parameter int BUZZ_CYCLES = 16
) (
    input  logic              CLK,
    input  logic              CLR,
    input  logic              TICK,
    input  logic              BTN_A,
    input  logic              BTN_B,
    input  logic              BTN_SP,
    input  logic              BTN_SET,
    input  logic              BTN_SEL,
    input  logic              BTN_DEC,
    input  logic              OVF_A,
    input  logic              OVF_B,
    output logic              CE_A,
    output logic              CE_B,
    output logic              IMPULSE_A,
    output logic              IMPULSE_B,
    output logic              TCLR,
    output logic [3:0]        DEC_A,
    output logic [3:0]        DEC_B,
    output logic [2:0]        SEL,
    output logic [2:0]        STATE,
    output logic              FLAG_A,
    output logic              FLAG_B,
    output logic [MOVE_W-1:0] MOVES,
    output logic              BUZZ
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SET     = 3'd1,
        READY   = 3'd2,
        RUN_A   = 3'd3,
        RUN_B   = 3'd4,
        PAUSE   = 3'd5,
        FLAGGED = 3'd6
    } state_t;

    // Loaded on flag entry; BUZZ stays high until this count reaches zero,
    // giving exactly BUZZ_CYCLES high cycles including the entry cycle.
    localparam logic [15:0] BUZZ_LOAD = 16'(BUZZ_CYCLES - 1);

    state_t              state, state_nx;
    logic                dir, dir_nx;
    logic [2:0]          sel_nx;
    logic                flag_a_nx, flag_b_nx;
    logic [MOVE_W-1:0]   moves_nx;
    logic [15:0]         buzz_cnt, buzz_cnt_nx;
    logic                buzz_nx;
    logic                tclr_nx;
    logic                imp_a_nx, imp_b_nx;
    logic [3:0]          dec_a_nx, dec_b_nx;
    logic                ce_nx;

    assign STATE = state;

    // State register and registered outputs; reset aborts any game in progress.
    always_ff @(posedge CLK) begin
        if (!CLR) begin
            state     <= IDLE;
            dir       <= 1'b0;
            SEL       <= 3'd0;
            FLAG_A    <= 1'b0;
            FLAG_B    <= 1'b0;
            MOVES     <= '0;
            buzz_cnt  <= 16'd0;
            BUZZ      <= 1'b0;
            TCLR      <= 1'b1;
            IMPULSE_A <= 1'b0;
            IMPULSE_B <= 1'b0;
            DEC_A     <= 4'd0;
            DEC_B     <= 4'd0;
            CE_A      <= 1'b0;
            CE_B      <= 1'b0;
        end else begin
            state     <= state_nx;
            dir       <= dir_nx;
            SEL       <= sel_nx;
            FLAG_A    <= flag_a_nx;
            FLAG_B    <= flag_b_nx;
            MOVES     <= moves_nx;
            buzz_cnt  <= buzz_cnt_nx;
            BUZZ      <= buzz_nx;
            TCLR      <= tclr_nx;
            IMPULSE_A <= imp_a_nx;
            IMPULSE_B <= imp_b_nx;
            DEC_A     <= dec_a_nx;
            DEC_B     <= dec_b_nx;
            CE_A      <= ce_nx;
            CE_B      <= ce_nx;
        end
    end

    // Next-state and next-output decode. In the run states overflow beats
    // start/pause, which beats the player button; a tick arriving with a
    // switch or pause still goes to the side that was running.
    always_comb begin
        state_nx    = state;
        dir_nx      = dir;
        sel_nx      = SEL;
        flag_a_nx   = FLAG_A;
        flag_b_nx   = FLAG_B;
        moves_nx    = MOVES;
        buzz_cnt_nx = buzz_cnt;
        buzz_nx     = 1'b0;
        tclr_nx     = 1'b0;
        imp_a_nx    = 1'b0;
        imp_b_nx    = 1'b0;
        dec_a_nx    = 4'd0;
        dec_b_nx    = 4'd0;

        case (state)
            IDLE: begin
                if (BTN_SET) begin
                    state_nx = SET;
                end else if (BTN_SP) begin
                    state_nx = READY;
                end
            end

            SET: begin
                // Decrement uses the digit selected before any same-cycle BTN_SEL.
                if (BTN_DEC) begin
                    if (SEL[2]) begin
                        dec_b_nx[SEL[1:0]] = 1'b1;
                    end else begin
                        dec_a_nx[SEL[1:0]] = 1'b1;
                    end
                end
                if (BTN_SET) begin
                    state_nx = IDLE;
                    sel_nx   = 3'd0;
                end else if (BTN_SEL) begin
                    sel_nx = SEL + 3'd1;
                end
            end

            READY: begin
                // Pressing your own button starts the opponent's clock.
                if (BTN_A && !BTN_B) begin
                    state_nx = RUN_B;
                end else if (BTN_B && !BTN_A) begin
                    state_nx = RUN_A;
                end
            end

            RUN_A: begin
                if (OVF_A) begin
                    state_nx    = FLAGGED;
                    flag_a_nx   = 1'b1;
                    buzz_nx     = 1'b1;
                    buzz_cnt_nx = BUZZ_LOAD;
                end else begin
                    imp_a_nx = TICK;
                    if (BTN_SP) begin
                        state_nx = PAUSE;
                        dir_nx   = 1'b0;
                    end else if (BTN_A) begin
                        state_nx = RUN_B;
                    end
                end
            end

            RUN_B: begin
                if (OVF_B) begin
                    state_nx    = FLAGGED;
                    flag_b_nx   = 1'b1;
                    buzz_nx     = 1'b1;
                    buzz_cnt_nx = BUZZ_LOAD;
                end else begin
                    imp_b_nx = TICK;
                    if (BTN_SP) begin
                        state_nx = PAUSE;
                        dir_nx   = 1'b1;
                    end else if (BTN_B) begin
                        state_nx = RUN_A;
                        // A full move completes when B hands the clock back to A.
                        if (MOVES != '1) begin
                            moves_nx = MOVES + 1'b1;
                        end
                    end
                end
            end

            PAUSE: begin
                if (BTN_SP) begin
                    state_nx = dir ? RUN_B : RUN_A;
                end else if (BTN_SET) begin
                    state_nx = IDLE;
                    tclr_nx  = 1'b1;
                end
            end

            FLAGGED: begin
                if (BTN_SP) begin
                    state_nx    = IDLE;
                    flag_a_nx   = 1'b0;
                    flag_b_nx   = 1'b0;
                    moves_nx    = '0;
                    buzz_cnt_nx = 16'd0;
                    tclr_nx     = 1'b1;
                end else if (buzz_cnt != 16'd0) begin
                    buzz_nx     = 1'b1;
                    buzz_cnt_nx = buzz_cnt - 16'd1;
                end
            end

            default: begin
                state_nx = IDLE;
            end
        endcase

        ce_nx = (state_nx != FLAGGED);
    end

endmodule

// File: tb/tb_chess_clock_ctrl.sv
// Directed bench for the chess clock sequencer: reset, set mode, turn
// switching, pause/resume, flagging with buzzer, and restart paths.

module tb_chess_clock_ctrl;

    logic       CLK = 1'b0;
    logic       CLR, TICK, BTN_A, BTN_B, BTN_SP, BTN_SET, BTN_SEL, BTN_DEC;
    logic       OVF_A, OVF_B;
    logic       CE_A, CE_B, IMPULSE_A, IMPULSE_B, TCLR, FLAG_A, FLAG_B, BUZZ;
    logic [3:0] DEC_A, DEC_B;
    logic [2:0] SEL, STATE;
    logic [7:0] MOVES;

    int total = 0;
    int bad   = 0;
    int buzz_hi;

    chess_clock_ctrl #(.MOVE_W(8), .BUZZ_CYCLES(16)) dut (
        .CLK(CLK), .CLR(CLR), .TICK(TICK),
        .BTN_A(BTN_A), .BTN_B(BTN_B), .BTN_SP(BTN_SP), .BTN_SET(BTN_SET),
        .BTN_SEL(BTN_SEL), .BTN_DEC(BTN_DEC), .OVF_A(OVF_A), .OVF_B(OVF_B),
        .CE_A(CE_A), .CE_B(CE_B), .IMPULSE_A(IMPULSE_A), .IMPULSE_B(IMPULSE_B),
        .TCLR(TCLR), .DEC_A(DEC_A), .DEC_B(DEC_B), .SEL(SEL), .STATE(STATE),
        .FLAG_A(FLAG_A), .FLAG_B(FLAG_B), .MOVES(MOVES), .BUZZ(BUZZ)
    );

    always #5 CLK = ~CLK;

    task automatic idle_inputs();
        TICK = 0; BTN_A = 0; BTN_B = 0; BTN_SP = 0; BTN_SET = 0;
        BTN_SEL = 0; BTN_DEC = 0; OVF_A = 0; OVF_B = 0;
    endtask

    // One clock; inputs applied before the call are sampled at the edge,
    // then inputs return to idle and outputs are sampled 1 ns later.
    task automatic cyc();
        @(posedge CLK);
        #1;
        idle_inputs();
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        idle_inputs();
        CLR = 0;
        cyc();
        cyc();
        chk("rst_state", 16'(STATE), 16'd0);
        chk("rst_tclr", 16'(TCLR), 16'd1);
        chk("rst_ce_a", 16'(CE_A), 16'd0);
        chk("rst_ce_b", 16'(CE_B), 16'd0);
        chk("rst_moves", 16'(MOVES), 16'd0);
        chk("rst_buzz", 16'(BUZZ), 16'd0);

        CLR = 1;
        cyc();
        chk("rel_tclr", 16'(TCLR), 16'd0);
        chk("rel_ce", 16'({CE_A, CE_B}), 16'b11);
        chk("rel_state", 16'(STATE), 16'd0);

        // Set mode: select B.TS (SEL=5) and decrement it.
        BTN_SET = 1; cyc();
        chk("set_state", 16'(STATE), 16'd1);
        for (int i = 0; i < 5; i++) begin
            BTN_SEL = 1; cyc();
        end
        chk("sel_5", 16'(SEL), 16'd5);
        BTN_DEC = 1; cyc();
        chk("dec_b_ts", 16'(DEC_B), 16'b0010);
        chk("dec_a_idle", 16'(DEC_A), 16'd0);
        cyc();
        chk("dec_b_pulse_end", 16'(DEC_B), 16'd0);
        for (int i = 0; i < 3; i++) begin
            BTN_SEL = 1; cyc();
        end
        chk("sel_wrap", 16'(SEL), 16'd0);
        // Same-cycle select and decrement: decrement hits the old digit (A.US).
        BTN_SEL = 1; BTN_DEC = 1; cyc();
        chk("dec_old_sel", 16'(DEC_A), 16'b0001);
        chk("sel_after_both", 16'(SEL), 16'd1);
        BTN_SET = 1; cyc();
        chk("set_exit_state", 16'(STATE), 16'd0);
        chk("set_exit_sel", 16'(SEL), 16'd0);

        // Ready; simultaneous player buttons do nothing.
        BTN_SP = 1; cyc();
        chk("ready_state", 16'(STATE), 16'd2);
        BTN_A = 1; BTN_B = 1; cyc();
        chk("ready_both", 16'(STATE), 16'd2);
        BTN_B = 1; cyc();
        chk("run_a_state", 16'(STATE), 16'd3);

        for (int i = 0; i < 3; i++) begin
            TICK = 1; cyc();
            chk("tick_imp_a", 16'({IMPULSE_A, IMPULSE_B}), 16'b10);
            cyc();
            chk("tick_gap", 16'({IMPULSE_A, IMPULSE_B}), 16'b00);
        end

        // Switch with a coincident tick: the tick still goes to A.
        BTN_A = 1; TICK = 1; cyc();
        chk("switch_imp_a", 16'({IMPULSE_A, IMPULSE_B}), 16'b10);
        chk("switch_state", 16'(STATE), 16'd4);

        // Tick in RUN_B goes to B; A's overflow is ignored while B runs.
        TICK = 1; OVF_A = 1; cyc();
        chk("run_b_imp", 16'({IMPULSE_A, IMPULSE_B}), 16'b01);
        chk("run_b_ovf_a_ign", 16'(STATE), 16'd4);
        chk("run_b_no_flag", 16'({FLAG_A, FLAG_B}), 16'b00);

        BTN_B = 1; cyc();
        chk("move_state", 16'(STATE), 16'd3);
        chk("moves_1", 16'(MOVES), 16'd1);

        // Pause from A, ticks and player buttons ignored, resume to A.
        BTN_SP = 1; cyc();
        chk("pause_state", 16'(STATE), 16'd5);
        for (int i = 0; i < 2; i++) begin
            TICK = 1; cyc();
            chk("pause_no_imp", 16'({IMPULSE_A, IMPULSE_B}), 16'b00);
        end
        BTN_A = 1; cyc();
        chk("pause_btn_ign", 16'(STATE), 16'd5);
        BTN_SP = 1; cyc();
        chk("resume_a", 16'(STATE), 16'd3);

        // Pause from B resumes to B.
        BTN_A = 1; cyc();
        BTN_SP = 1; cyc();
        chk("pause_b_state", 16'(STATE), 16'd5);
        BTN_SP = 1; cyc();
        chk("resume_b", 16'(STATE), 16'd4);
        BTN_B = 1; cyc();
        chk("moves_2", 16'(MOVES), 16'd2);

        // Overflow beats start/pause; coincident tick is dropped.
        OVF_A = 1; BTN_SP = 1; TICK = 1; cyc();
        chk("flag_state", 16'(STATE), 16'd6);
        chk("flag_bits", 16'({FLAG_A, FLAG_B}), 16'b10);
        chk("flag_no_imp", 16'({IMPULSE_A, IMPULSE_B}), 16'b00);
        chk("flag_ce", 16'({CE_A, CE_B}), 16'b00);
        buzz_hi = BUZZ ? 1 : 0;
        for (int i = 0; i < 24; i++) begin
            cyc();
            if (BUZZ) buzz_hi++;
        end
        chk("buzz_len", 16'(buzz_hi), 16'd16);
        chk("buzz_off", 16'(BUZZ), 16'd0);
        chk("flag_hold", 16'({FLAG_A, FLAG_B}), 16'b10);
        chk("flag_moves_hold", 16'(MOVES), 16'd2);

        BTN_SP = 1; cyc();
        chk("exit_state", 16'(STATE), 16'd0);
        chk("exit_tclr", 16'(TCLR), 16'd1);
        chk("exit_flag", 16'({FLAG_A, FLAG_B}), 16'b00);
        chk("exit_moves", 16'(MOVES), 16'd0);
        chk("exit_ce", 16'({CE_A, CE_B}), 16'b11);
        cyc();
        chk("exit_tclr_end", 16'(TCLR), 16'd0);

        // Abort from pause via set button pulses TCLR.
        BTN_SP = 1; cyc();
        BTN_B = 1; cyc();
        BTN_SP = 1; cyc();
        BTN_SET = 1; cyc();
        chk("pause_abort_state", 16'(STATE), 16'd0);
        chk("pause_abort_tclr", 16'(TCLR), 16'd1);

        // Reset mid-game: no impulse on the reset cycle.
        BTN_SP = 1; cyc();
        BTN_B = 1; cyc();
        chk("rerun_a", 16'(STATE), 16'd3);
        CLR = 0; TICK = 1; cyc();
        chk("midrst_imp", 16'({IMPULSE_A, IMPULSE_B}), 16'b00);
        chk("midrst_state", 16'(STATE), 16'd0);
        chk("midrst_tclr", 16'(TCLR), 16'd1);
        CLR = 1; cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
